// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modular-exponentiation sequencer.
package modexp_pkg;

   localparam int WIDTH_DEF = 1024;
   localparam int EBITS_DEF = 1024;

   typedef enum logic [3:0] {
      IDLE,
      ISSUE_TOMONT,
      WAIT_TOMONT,
      SCAN,
      ISSUE_SQR,
      WAIT_SQR,
      ISSUE_MUL,
      WAIT_MUL,
      STEP,
      ISSUE_FROM,
      WAIT_FROM,
      DONE
   } state_e;

   function automatic logic is_issue(state_e s);
      return s inside {ISSUE_TOMONT, ISSUE_SQR, ISSUE_MUL, ISSUE_FROM};
   endfunction

endpackage

// File: rtl/modexp_exp_scanner.sv
// Exponent shift register plus remaining-bit counter; presents the current MSB
// and flags when the bit under inspection is the final one.
module modexp_exp_scanner
   import modexp_pkg::*;
#(
   parameter int EBITS = EBITS_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load_i,
   input  logic [EBITS-1:0] e_i,
   input  logic             shift_i,
   output logic             msb_o,
   output logic             last_o
);

   localparam int CW = $clog2(EBITS + 1);

   logic [EBITS-1:0] e_q, e_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_q   <= '0;
         cnt_q <= '0;
      end else begin
         e_q   <= e_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      e_d   = e_q;
      cnt_d = cnt_q;
      if (load_i) begin
         e_d   = e_i;
         cnt_d = CW'(EBITS);
      end else if (shift_i) begin
         e_d   = e_q << 1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign msb_o  = e_q[EBITS-1];
   assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/modexp_ctrl.sv
// Square-and-multiply sequencer computing X^E mod M through an external
// Montgomery multiplier driven over a start/done handshake.
module modexp_ctrl
   import modexp_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int EBITS = EBITS_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_x,
   input  logic [EBITS-1:0] in_e,
   input  logic [WIDTH-1:0] in_m,
   input  logic [WIDTH-1:0] in_r,
   input  logic [WIDTH-1:0] in_r2,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             mm_start,
   output logic [WIDTH-1:0] mm_a,
   output logic [WIDTH-1:0] mm_b,
   output logic [WIDTH-1:0] mm_m,
   input  logic [WIDTH-1:0] mm_result,
   input  logic             mm_done
);

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] xm_q, xm_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] mm_a_q, mm_a_d;
   logic [WIDTH-1:0] mm_b_q, mm_b_d;

   logic scan_load, scan_shift, bit_msb, bit_last;

   modexp_exp_scanner #(.EBITS(EBITS)) u_scanner (
      .clk     (clk),
      .resetn  (resetn),
      .load_i  (scan_load),
      .e_i     (in_e),
      .shift_i (scan_shift),
      .msb_o   (bit_msb),
      .last_o  (bit_last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         a_q     <= '0;
         xm_q    <= '0;
         m_q     <= '0;
         res_q   <= '0;
         mm_a_q  <= '0;
         mm_b_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         xm_q    <= xm_d;
         m_q     <= m_d;
         res_q   <= res_d;
         mm_a_q  <= mm_a_d;
         mm_b_q  <= mm_b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:         if (start) state_d = ISSUE_TOMONT;
         ISSUE_TOMONT: state_d = WAIT_TOMONT;
         WAIT_TOMONT:  if (mm_done) state_d = SCAN;
         SCAN: begin
            if (bit_msb)       state_d = ISSUE_SQR;
            else if (bit_last) state_d = ISSUE_FROM;
         end
         ISSUE_SQR:    state_d = WAIT_SQR;
         WAIT_SQR:     if (mm_done) state_d = bit_msb ? ISSUE_MUL : STEP;
         ISSUE_MUL:    state_d = WAIT_MUL;
         WAIT_MUL:     if (mm_done) state_d = STEP;
         STEP:         state_d = bit_last ? ISSUE_FROM : ISSUE_SQR;
         ISSUE_FROM:   state_d = WAIT_FROM;
         WAIT_FROM:    if (mm_done) state_d = DONE;
         DONE:         state_d = IDLE;
         default:      state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d    = a_q;
      xm_d   = xm_q;
      m_d    = m_q;
      res_d  = res_q;
      mm_a_d = mm_a_q;
      mm_b_d = mm_b_q;
      case (state_q)
         IDLE: if (start) begin
            a_d = in_r;
            m_d = in_m;
         end
         WAIT_TOMONT:        if (mm_done) xm_d = mm_result;
         WAIT_SQR, WAIT_MUL: if (mm_done) a_d = mm_result;
         WAIT_FROM:          if (mm_done) res_d = mm_result;
         default: ;
      endcase
      // Operands are loaded on the edge entering an ISSUE state so they are
      // valid alongside mm_start and untouched until the next issue.
      case (state_d)
         ISSUE_TOMONT: begin
            mm_a_d = in_x;
            mm_b_d = in_r2;
         end
         ISSUE_SQR: begin
            mm_a_d = a_d;
            mm_b_d = a_d;
         end
         ISSUE_MUL: begin
            mm_a_d = a_d;
            mm_b_d = xm_q;
         end
         ISSUE_FROM: begin
            mm_a_d = a_d;
            mm_b_d = WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      mm_start   = is_issue(state_q);
      done       = (state_q == DONE);
      busy       = (state_q != IDLE);
      scan_load  = (state_q == IDLE) && start;
      scan_shift = ((state_q == SCAN) && !bit_msb) || (state_q == STEP);
   end

   assign result = res_q;
   assign mm_a   = mm_a_q;
   assign mm_b   = mm_b_q;
   assign mm_m   = m_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Randomised bench for modexp_ctrl with a behavioural Montgomery multiplier
// of configurable latency and a plain-arithmetic modpow reference.
module tb_modexp_ctrl;

   localparam int W  = 8;
   localparam int EB = 8;

   logic          clk, resetn, start, done, busy, mm_start, mm_done;
   logic [W-1:0]  in_x, in_m, in_r, in_r2, result, mm_a, mm_b, mm_m, mm_result;
   logic [EB-1:0] in_e;

   int checks = 0;
   int errors = 0;

   int lat_cfg = 3;
   int pending = 0, wait_cnt = 0, pulses = 0, stab_err = 0, overlap_err = 0;
   bit spur_arm = 0;
   int spur_cnt = 0;
   logic [W-1:0] cap_a, cap_b, cap_m, cap_res;

   modexp_ctrl #(.WIDTH(W), .EBITS(EB)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .in_x      (in_x),
      .in_e      (in_e),
      .in_m      (in_m),
      .in_r      (in_r),
      .in_r2     (in_r2),
      .result    (result),
      .done      (done),
      .busy      (busy),
      .mm_start  (mm_start),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_m      (mm_m),
      .mm_result (mm_result),
      .mm_done   (mm_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int inv_r(input int m);
      for (int k = 1; k < m; k++)
         if ((256 * k) % m == 1) return k;
      return 0;
   endfunction

   // a*b*R^-1 mod m, R = 2^W
   function automatic int mont(input int a, input int b, input int m);
      return ((a * b) % m) * inv_r(m) % m;
   endfunction

   function automatic int modpow(input int x, input int e, input int m);
      int r;
      r = 1 % m;
      for (int i = 0; i < e; i++) r = (r * x) % m;
      return r;
   endfunction

   function automatic int sig_bits(input int e);
      int n;
      n = 0;
      for (int i = 0; i < EB; i++) if (e[i]) n = i + 1;
      return n;
   endfunction

   function automatic int popc(input int e);
      int w;
      w = 0;
      for (int i = 0; i < EB; i++) if (e[i]) w++;
      return w;
   endfunction

   // start-cycle through done-cycle inclusive
   function automatic int exp_cycles(input int e, input int lat);
      int n, w, scan;
      n    = sig_bits(e);
      w    = popc(e);
      scan = (e == 0) ? EB : (EB - n) + 1;
      return 1 + (lat + 1) + scan + n * (lat + 2) + w * (lat + 1) + (lat + 1) + 1;
   endfunction

   // Multiplier model: accepts mm_start, answers L cycles later, and can
   // inject one stray mm_done a couple of cycles after the first answer.
   initial begin : mm_model
      mm_done   = 1'b0;
      mm_result = '0;
      forever begin
         @(negedge clk);
         mm_done = 1'b0;
         if (resetn !== 1'b1) begin
            pending  = 0;
            spur_cnt = 0;
         end else if (pending != 0) begin
            if (mm_a !== cap_a || mm_b !== cap_b || mm_m !== cap_m) stab_err++;
            if (mm_start !== 1'b0) overlap_err++;
            wait_cnt--;
            if (wait_cnt == 0) begin
               mm_done   = 1'b1;
               mm_result = cap_res;
               pending   = 0;
               if (spur_arm) begin
                  spur_arm = 0;
                  spur_cnt = 2;
               end
            end
         end else if (mm_start === 1'b1) begin
            pulses++;
            cap_a    = mm_a;
            cap_b    = mm_b;
            cap_m    = mm_m;
            cap_res  = W'(mont(int'(mm_a), int'(mm_b), int'(mm_m)));
            wait_cnt = lat_cfg;
            pending  = 1;
         end else if (spur_cnt > 0) begin
            spur_cnt--;
            if (spur_cnt == 0) begin
               mm_done   = 1'b1;
               mm_result = 8'hA5;
            end
         end
      end
   end

   // Called at a negedge with the DUT idle.
   task automatic run_exp(input int x, input int e, input int m, input int lat, input bit disturb);
      int  exp_res, exp_cyc, k, ndone, got_res, cyc, r;
      bit  got;
      exp_res     = modpow(x, e, m);
      exp_cyc     = exp_cycles(e, lat);
      r           = 256 % m;
      lat_cfg     = lat;
      pulses      = 0;
      stab_err    = 0;
      overlap_err = 0;
      spur_arm    = disturb;
      in_x  = W'(x);
      in_e  = EB'(e);
      in_m  = W'(m);
      in_r  = W'(r);
      in_r2 = W'((r * r) % m);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      k = 1; got = 0; ndone = 0; got_res = 0; cyc = 0;
      while (!got && k < 3000) begin
         if (done === 1'b1) begin
            got     = 1;
            cyc     = k + 1;
            got_res = int'(result);
            ndone++;
         end else begin
            if (disturb && k == 4) begin
               start = 1'b1;
               in_x  = W'(m - 1);
               in_e  = 8'h01;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            k++;
         end
      end
      start = 1'b0;
      if (!got) check("done_timeout", 0, 1);
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      $display("run x=%0d e=%0d m=%0d L=%0d dist=%0d result=%0d cycles=%0d", x, e, m, lat, disturb, got_res, cyc);
      check("result", got_res, exp_res);
      check("latency", cyc, exp_cyc);
      check("done_count", ndone, 1);
      check("mm_pulses", pulses, 2 + sig_bits(e) + popc(e));
      check("operand_stable", stab_err, 0);
      check("start_overlap", overlap_err, 0);
      check("result_held", result, exp_res);
   endtask

   initial begin : main
      int k, m, x, e, lat;
      resetn = 1'b0;
      start  = 1'b0;
      in_x = '0; in_e = '0; in_m = '0; in_r = '0; in_r2 = '0;
      repeat (2) @(negedge clk);
      check("rst_result", result, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_mm_start", mm_start, 0);
      check("rst_mm_a", mm_a, 0);
      check("rst_mm_b", mm_b, 0);
      check("rst_mm_m", mm_m, 0);
      resetn = 1'b1;
      @(negedge clk);

      run_exp(2, 5, 13, 3, 0);
      run_exp(7, 0, 13, 3, 0);
      run_exp(5, 1, 13, 4, 0);
      run_exp(12, 255, 13, 2, 0);
      run_exp(6, 8'h0B, 13, 5, 1);
      run_exp(12, 255, 13, 2, 0);

      // asynchronous reset while a squaring is outstanding
      lat_cfg = 10; pulses = 0;
      in_x = 8'd3; in_e = 8'hFF; in_m = 8'd13; in_r = 8'd9; in_r2 = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (pulses < 2 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("sqr_issued", pulses, 2);
      repeat (3) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      #1 resetn = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_result", result, 0);
      check("arst_mm_a", mm_a, 0);
      check("arst_mm_b", mm_b, 0);
      check("arst_mm_m", mm_m, 0);
      check("arst_mm_start", mm_start, 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      run_exp(3, 8'hFF, 13, 10, 0);

      for (int i = 0; i < 20; i++) begin
         m   = 2 * $urandom_range(1, 127) + 1;
         x   = $urandom_range(0, m - 1);
         e   = $urandom_range(0, 255);
         lat = $urandom_range(1, 20);
         run_exp(x, e, m, lat, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Modular-exponentiation sequencer that computes X^E mod M by square-and-multiply. It is the initiator of the Montgomery multiplier's start/done interface: it drives operands and single-cycle start pulses into one multiplier instance and consumes its result on done. It sits between the top-level register file and the multiplier.

## Interface
- WIDTH, 1024, modulus/operand width; R = 2^WIDTH
- EBITS, 1024, exponent width
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- in_x  in  WIDTH  base, < M
- in_e  in  EBITS  exponent
- in_m  in  WIDTH  odd modulus, > 1
- in_r  in  WIDTH  R mod M
- in_r2  in  WIDTH  R^2 mod M
- result  out  WIDTH  X^E mod M; reset 0
- done  out  1  one-cycle pulse, result valid; reset 0
- busy  out  1  high from the cycle after start until the done cycle inclusive; reset 0
- mm_start  out  1  multiplier start pulse; reset 0
- mm_a, mm_b  out  WIDTH  multiplier operands, registered; reset 0
- mm_m  out  WIDTH  latched in_m; reset 0
- mm_result  in  WIDTH  multiplier output, valid when mm_done=1
- mm_done  in  1  multiplier completion pulse

## Operation
- IDLE: on start, latch in_x, in_e, in_m, in_r, in_r2; set A=in_r, count=EBITS; go ISSUE_TOMONT.
- ISSUE_TOMONT: mm_a=x, mm_b=r2, mm_start=1 -> WAIT_TOMONT; on mm_done, Xm=mm_result -> SCAN.
- SCAN: one cycle per exponent bit; if E[EBITS-1]=0, shift E left, decrement count, stay; if 1 -> ISSUE_SQR; if count reaches 0 (E=0) -> ISSUE_FROM.
- ISSUE_SQR: mm_a=mm_b=A, pulse -> WAIT_SQR; on mm_done A=mm_result; -> ISSUE_MUL if current bit=1, else STEP.
- ISSUE_MUL: mm_a=A, mm_b=Xm, pulse -> WAIT_MUL; on mm_done A=mm_result -> STEP.
- STEP: shift E left, decrement count; count=0 -> ISSUE_FROM, else ISSUE_SQR.
- ISSUE_FROM: mm_a=A, mm_b=1, pulse -> WAIT_FROM; on mm_done result=mm_result -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- mm_a/mm_b/mm_m held stable from mm_start until matching mm_done.
- mm_done outside a WAIT state ignored; start while busy ignored.
- resetn low at any time: all state/outputs to reset values immediately, no pending multiplication is tracked afterward.
- E=0 returns 1 mod M (=1); result held until next done.

## Timing
- Let L = cycles from mm_start cycle to mm_done cycle. Each multiplication costs L+1 cycles (issue + wait incl. done cycle).
- Latency start->done, z = leading zeros of E, n = EBITS-z, w = popcount(E): 1 + (L+1) + (z+1) + (n+w)(L+1) + (n-1)... precisely: capture 1, TOMONT L+1, SCAN z+1 (EBITS if E=0), per processed bit (L+1)(1+bit)+1 STEP, FROM L+1, DONE 1.
- mm_start never high in two consecutive cycles; never high while a multiplication is outstanding.
- done and result change on the same edge only in DONE entry; result already valid in the done cycle.

## Structure
- modexp_pkg: state enum (IDLE, ISSUE_TOMONT, WAIT_TOMONT, SCAN, ISSUE_SQR, WAIT_SQR, ISSUE_MUL, WAIT_MUL, STEP, ISSUE_FROM, WAIT_FROM, DONE), WIDTH/EBITS defaults.
- One sub-module: modexp_exp_scanner (exponent shift register + bit counter, outputs msb and last).

## Test plan
Bench uses a behavioural Montgomery model with configurable L; WIDTH=8, EBITS=8, M=13, R mod M=9, R^2 mod M=3.
- x=2, e=5, L=3 -> result=6, done once, latency matches formula (z=5, n=3, w=2).
- x=7, e=0 -> result=1; no ISSUE_SQR/ISSUE_MUL pulses observed.
- x=5, e=1 -> result=5; x=12, e=255 -> result=12^255 mod 13=12.
- start pulsed again while busy, spurious mm_done in SCAN -> ignored, result unchanged from undisturbed run.
- resetn dropped mid WAIT_SQR -> outputs 0 asynchronously; fresh start afterwards gives correct result.
- L varied 1..20 -> mm_a/mm_b stable between each mm_start and mm_done; same results.
